executor_merge: RTL and testbench

// Locks the falling tetromino into the playfield matrix memory just before line clearing.

---
 rtl/tetris_pkg.sv | 20 ++
 rtl/executor_merge_if.sv | 27 ++
 rtl/merge_row_mask.sv | 21 ++
 rtl/executor_merge.sv | 141 ++++++++++++++
 tb/tb_executor_merge.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/tetris_pkg.sv
// Shared types and helpers for the tetromino lock/merge path.
package tetris_pkg;

  localparam int PIECE_DIM_C = 4;

  typedef enum bit [1:0] {
    eIDLE  = 2'd0,
    eMerge = 2'd1,
    eKick  = 2'd2,
    eWait  = 2'd3
  } merge_state_e;

  function automatic logic [PIECE_DIM_C-1:0] shape_row(
    input logic [PIECE_DIM_C*PIECE_DIM_C-1:0] shape,
    input logic [1:0]                         r
  );
    return shape[PIECE_DIM_C*r +: PIECE_DIM_C];
  endfunction

endpackage

// File: rtl/executor_merge_if.sv
// Merge request/response handshake between the game controller and executor_merge.
interface executor_merge_if #(
  parameter int width_p  = 16,
  parameter int height_p = 32
);
  localparam int x_w_lp = $clog2(width_p);
  localparam int y_w_lp = $clog2(height_p);

  logic              v_i;
  logic              ready_o;
  logic [15:0]       shape_i;
  logic [x_w_lp-1:0] pos_x_i;
  logic [y_w_lp-1:0] pos_y_i;
  logic              done_o;
  logic [2:0]        lines_o;
  logic              err_o;

  modport master (
    output v_i, shape_i, pos_x_i, pos_y_i,
    input  ready_o, done_o, lines_o, err_o
  );

  modport slave (
    input  v_i, shape_i, pos_x_i, pos_y_i,
    output ready_o, done_o, lines_o, err_o
  );
endinterface

// File: rtl/merge_row_mask.sv
// Places one 4-bit piece row at column pos_x; flags bits pushed past the right edge.
module merge_row_mask
  import tetris_pkg::*;
#(
  parameter int width_p = 16
) (
  input  logic [PIECE_DIM_C-1:0]     shape_row,
  input  logic [$clog2(width_p)-1:0] pos_x,
  output logic [width_p-1:0]         mask,
  output logic                       clipped
);

  logic [width_p+PIECE_DIM_C-1:0] wide;

  always_comb begin
    wide    = {{width_p{1'b0}}, shape_row} << pos_x;
    mask    = wide[width_p-1:0];
    clipped = |wide[width_p+PIECE_DIM_C-1:width_p];
  end

endmodule

// File: rtl/executor_merge.sv
// Locks a 4x4 piece into the playfield by read-modify-write, then hands the
// matrix port to the line-check stage and reports its cleared-row count.
//
// state  | meaning
// eIDLE  | ready for a merge request
// eMerge | OR one piece row into the matrix per cycle, rows 0..3
// eKick  | one-cycle start pulse to the line-check stage
// eWait  | matrix port forwarded to the line-check stage until it reports done
module executor_merge
  import tetris_pkg::*;
#(
  parameter int width_p  = 16,
  parameter int height_p = 32
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  executor_merge_if.slave             req,
  output logic                        check_v_o,
  input  logic                        check_done_i,
  input  logic [2:0]                  check_lines_i,
  input  logic [$clog2(height_p)-1:0] chk_mm_read_addr_i,
  input  logic [$clog2(height_p)-1:0] chk_mm_write_addr_i,
  input  logic [width_p-1:0]          chk_mm_write_data_i,
  input  logic                        chk_mm_write_v_i,
  output logic [$clog2(height_p)-1:0] mm_read_addr_o,
  input  logic [width_p-1:0]          mm_read_data_i,
  output logic [$clog2(height_p)-1:0] mm_write_addr_o,
  output logic [width_p-1:0]          mm_write_data_o,
  output logic                        mm_write_v_o
);

  localparam int x_w_lp = $clog2(width_p);
  localparam int y_w_lp = $clog2(height_p);

  merge_state_e      state_r, state_n;
  logic [1:0]        row_r;
  logic [15:0]       shape_r;
  logic [x_w_lp-1:0] pos_x_r;
  logic [y_w_lp-1:0] pos_y_r;
  logic              err_r;
  logic [2:0]        lines_r;

  // One extra bit so rows below the floor are detected instead of wrapping to the top.
  logic [y_w_lp:0]      row_addr;
  logic                 in_range;
  logic [PIECE_DIM_C-1:0] cur_row;
  logic [width_p-1:0]   mask;
  logic                 clipped;
  logic                 row_err;
  logic                 done;

  assign row_addr = {1'b0, pos_y_r} + {{(y_w_lp-1){1'b0}}, row_r};
  assign in_range = row_addr < (y_w_lp+1)'(height_p);
  assign cur_row  = shape_row(shape_r, row_r);

  merge_row_mask #(.width_p(width_p)) u_mask (
    .shape_row (cur_row),
    .pos_x     (pos_x_r),
    .mask      (mask),
    .clipped   (clipped)
  );

  assign row_err = in_range ? ((|(mm_read_data_i & mask)) | clipped) : (|cur_row);

  always_comb begin
    state_n         = state_r;
    check_v_o       = 1'b0;
    done            = 1'b0;
    mm_read_addr_o  = '0;
    mm_write_addr_o = '0;
    mm_write_data_o = '0;
    mm_write_v_o    = 1'b0;
    case (state_r)
      eIDLE: begin
        if (req.v_i) state_n = eMerge;
      end
      eMerge: begin
        mm_read_addr_o  = row_addr[y_w_lp-1:0];
        mm_write_addr_o = row_addr[y_w_lp-1:0];
        mm_write_data_o = mm_read_data_i | mask;
        mm_write_v_o    = in_range;
        if (row_r == 2'd3) state_n = eKick;
      end
      eKick: begin
        check_v_o = 1'b1;
        state_n   = eWait;
      end
      eWait: begin
        mm_read_addr_o  = chk_mm_read_addr_i;
        mm_write_addr_o = chk_mm_write_addr_i;
        mm_write_data_o = chk_mm_write_data_i;
        mm_write_v_o    = chk_mm_write_v_i;
        if (check_done_i) begin
          done    = 1'b1;
          state_n = eIDLE;
        end
      end
      default: state_n = eIDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= eIDLE;
      row_r   <= '0;
      shape_r <= '0;
      pos_x_r <= '0;
      pos_y_r <= '0;
      err_r   <= 1'b0;
      lines_r <= '0;
    end else begin
      state_r <= state_n;
      case (state_r)
        eIDLE: begin
          if (req.v_i) begin
            shape_r <= req.shape_i;
            pos_x_r <= req.pos_x_i;
            pos_y_r <= req.pos_y_i;
            row_r   <= '0;
            err_r   <= 1'b0;
          end
        end
        eMerge: begin
          row_r <= row_r + 2'd1;
          if (row_err) err_r <= 1'b1;
        end
        eWait: begin
          if (check_done_i) lines_r <= check_lines_i;
        end
        default: ;
      endcase
    end
  end

  // The count is visible in the done cycle itself, then held from the register.
  assign req.ready_o = (state_r == eIDLE);
  assign req.done_o  = done;
  assign req.lines_o = done ? check_lines_i : lines_r;
  assign req.err_o   = err_r;

endmodule

// File: tb/tb_executor_merge.sv
// Directed bench for executor_merge with a behavioural matrix memory.
module tb_executor_merge;

  localparam int W = 16;
  localparam int H = 32;

  logic clk_i = 1'b0;
  logic reset_i;
  always #5 clk_i = ~clk_i;

  executor_merge_if #(.width_p(W), .height_p(H)) req ();

  logic        check_v_o;
  logic        check_done_i;
  logic [2:0]  check_lines_i;
  logic [4:0]  chk_mm_read_addr_i, chk_mm_write_addr_i;
  logic [15:0] chk_mm_write_data_i;
  logic        chk_mm_write_v_i;
  logic [4:0]  mm_read_addr_o, mm_write_addr_o;
  logic [15:0] mm_read_data_i, mm_write_data_o;
  logic        mm_write_v_o;

  executor_merge #(.width_p(W), .height_p(H)) dut (
    .clk_i               (clk_i),
    .reset_i             (reset_i),
    .req                 (req),
    .check_v_o           (check_v_o),
    .check_done_i        (check_done_i),
    .check_lines_i       (check_lines_i),
    .chk_mm_read_addr_i  (chk_mm_read_addr_i),
    .chk_mm_write_addr_i (chk_mm_write_addr_i),
    .chk_mm_write_data_i (chk_mm_write_data_i),
    .chk_mm_write_v_i    (chk_mm_write_v_i),
    .mm_read_addr_o      (mm_read_addr_o),
    .mm_read_data_i      (mm_read_data_i),
    .mm_write_addr_o     (mm_write_addr_o),
    .mm_write_data_o     (mm_write_data_o),
    .mm_write_v_o        (mm_write_v_o)
  );

  logic [15:0] mem [H];
  logic        poke_v = 1'b0;
  logic [4:0]  poke_addr = '0;
  logic [15:0] poke_data = '0;
  int          n_wr = 0;

  assign mm_read_data_i = mem[mm_read_addr_o];

  always @(posedge clk_i) begin
    if (poke_v) mem[poke_addr] <= poke_data;
    if (mm_write_v_o) begin
      mem[mm_write_addr_o] <= mm_write_data_o;
      n_wr <= n_wr + 1;
    end
  end

  int n_vec = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [4:0] a, input logic [15:0] d);
    @(negedge clk_i);
    poke_v = 1'b1; poke_addr = a; poke_data = d;
    @(negedge clk_i);
    poke_v = 1'b0;
  endtask

  // Accept at cycle 0, merge cycles 1-4, kick in cycle 5; returns in the first eWait cycle.
  // check_done_i is held high through merge/kick to show it is ignored there.
  task automatic merge_to_wait(input logic [15:0] s, input logic [3:0] x, input logic [4:0] y,
                               input string tag, output int wr0);
    @(negedge clk_i);
    req.v_i = 1'b1; req.shape_i = s; req.pos_x_i = x; req.pos_y_i = y;
    chk({tag, " ready"}, req.ready_o, 1);
    wr0 = n_wr;
    @(negedge clk_i);
    req.v_i = 1'b0;
    check_done_i = 1'b1; check_lines_i = 3'd7;
    chk({tag, " err cleared on accept"}, req.err_o, 0);
    for (int c = 1; c <= 4; c++) begin
      chk({tag, " no early kick"}, check_v_o, 0);
      chk({tag, " done ignored in merge"}, req.done_o, 0);
      @(negedge clk_i);
    end
    chk({tag, " kick cycle5"}, check_v_o, 1);
    chk({tag, " done ignored in kick"}, req.done_o, 0);
    check_done_i = 1'b0;
    @(negedge clk_i);
    chk({tag, " kick single"}, check_v_o, 0);
  endtask

  task automatic finish_check(input logic [2:0] lines, input string tag);
    check_lines_i = lines; check_done_i = 1'b1;
    #1;
    chk({tag, " done pulse"}, req.done_o, 1);
    chk({tag, " lines with done"}, req.lines_o, lines);
    @(negedge clk_i);
    check_done_i = 1'b0;
    #1;
    chk({tag, " done low"}, req.done_o, 0);
    chk({tag, " back idle"}, req.ready_o, 1);
    chk({tag, " lines held"}, req.lines_o, lines);
  endtask

  int w;

  initial begin
    reset_i = 1'b1;
    req.v_i = 1'b0; req.shape_i = '0; req.pos_x_i = '0; req.pos_y_i = '0;
    check_done_i = 1'b0; check_lines_i = '0;
    chk_mm_read_addr_i = '0; chk_mm_write_addr_i = '0;
    chk_mm_write_data_i = '0; chk_mm_write_v_i = 1'b0;
    for (int i = 0; i < H; i++) poke(5'(i), 16'h0000);
    @(negedge clk_i);
    chk("rst ready", req.ready_o, 1);
    chk("rst done", req.done_o, 0);
    chk("rst check_v", check_v_o, 0);
    chk("rst err", req.err_o, 0);
    chk("rst lines", req.lines_o, 0);
    chk("rst wv", mm_write_v_o, 0);
    reset_i = 1'b0;

    // T-piece into empty matrix
    merge_to_wait(16'h0072, 4'd3, 5'd10, "tpiece", w);
    chk("tpiece writes", n_wr - w, 4);
    chk("tpiece row10", mem[10], 16'h0010);
    chk("tpiece row11", mem[11], 16'h0038);
    chk("tpiece row12", mem[12], 16'h0000);
    chk("tpiece row13", mem[13], 16'h0000);
    chk("tpiece err", req.err_o, 0);
    finish_check(3'd0, "tpiece");

    // I-piece on the bottom row; rows past the floor must not wrap
    poke(5'd31, 16'hFFFE);
    merge_to_wait(16'h000F, 4'd0, 5'd31, "bottom", w);
    chk("bottom writes", n_wr - w, 1);
    chk("bottom row31", mem[31], 16'hFFFF);
    chk("bottom row0", mem[0], 16'h0000);
    chk("bottom err overlap", req.err_o, 1);
    finish_check(3'd1, "bottom");

    // Overlap on an occupied cell
    poke(5'd5, 16'h0001);
    merge_to_wait(16'h0001, 4'd0, 5'd5, "overlap", w);
    chk("overlap row5", mem[5], 16'h0001);
    chk("overlap err", req.err_o, 1);
    finish_check(3'd0, "overlap");
    @(negedge clk_i);
    chk("overlap err sticky idle", req.err_o, 1);

    // Clipped at the right edge, plus eWait forwarding of the check stage port
    merge_to_wait(16'h000F, 4'd14, 5'd20, "clip", w);
    chk("clip row20", mem[20], 16'hC000);
    chk("clip err", req.err_o, 1);
    chk_mm_write_v_i = 1'b1; chk_mm_write_addr_i = 5'd7;
    chk_mm_write_data_i = 16'hABCD; chk_mm_read_addr_i = 5'd9;
    #1;
    chk("fwd wv", mm_write_v_o, 1);
    chk("fwd waddr", mm_write_addr_o, 5'd7);
    chk("fwd wdata", mm_write_data_o, 16'hABCD);
    chk("fwd raddr", mm_read_addr_o, 5'd9);
    finish_check(3'd3, "clip");
    chk("idle wv", mm_write_v_o, 0);
    chk("idle waddr", mm_write_addr_o, 0);
    chk("idle raddr", mm_read_addr_o, 0);
    chk_mm_write_v_i = 1'b0;

    // v_i held through eWait: ignored, then accepted right after done
    merge_to_wait(16'h0000, 4'd0, 5'd0, "hold", w);
    req.v_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      chk("hold ready low", req.ready_o, 0);
      chk("hold no kick", check_v_o, 0);
      @(negedge clk_i);
    end
    check_done_i = 1'b1; check_lines_i = 3'd4;
    #1;
    chk("hold done", req.done_o, 1);
    @(negedge clk_i);
    check_done_i = 1'b0;
    chk("hold idle after done", req.ready_o, 1);
    @(negedge clk_i);
    req.v_i = 1'b0;
    chk("hold accepted", req.ready_o, 0);
    for (int c = 1; c < 4; c++) @(negedge clk_i);
    @(negedge clk_i);
    chk("hold second kick", check_v_o, 1);
    @(negedge clk_i);
    finish_check(3'd2, "hold2");

    // Reset in the middle of the merge
    @(negedge clk_i);
    req.v_i = 1'b1; req.shape_i = 16'h0001; req.pos_x_i = 4'd0; req.pos_y_i = 5'd5;
    @(negedge clk_i);
    req.v_i = 1'b0;
    @(negedge clk_i);
    chk("rstmid err before", req.err_o, 1);
    @(negedge clk_i);
    reset_i = 1'b1;
    @(negedge clk_i);
    reset_i = 1'b0;
    chk("rstmid idle", req.ready_o, 1);
    chk("rstmid wv", mm_write_v_o, 0);
    chk("rstmid waddr", mm_write_addr_o, 0);
    chk("rstmid err", req.err_o, 0);
    for (int c = 0; c < 6; c++) begin
      chk("rstmid no kick", check_v_o, 0);
      @(negedge clk_i);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
